// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
// Game-state and obstacle engine for the Flappy Bird VGA design: play FSM,
// NUM_PIPES scrolling pipes with randomised gaps, bird/pipe collision
// detection, and current/high score.
//
// Ports:
//   clk        system clock (single clock domain)
//   clr        synchronous active-high reset (also clears high_score)
//   tick       one-cycle scroll strobe
//   jump       start request (READY -> PLAY)
//   pause_btn  pause toggle; rising edge detected internally
//   restart    return to READY (keeps high_score)
//   bird_y     bird centre y, 0 = top of screen
//   rand_byte  random byte for new gap positions. The port is not called
//              "rand" because that is a reserved SystemVerilog keyword.
//   state      0=LOST, 1=READY, 2=PLAY, 3=PAUSE
//   pipe_x     right edge of pipe i at [i*X_W +: X_W]
//   gap_y      gap top of pipe i at [i*Y_W +: Y_W]
//   score      current score, saturating
//   high_score best score
//   hit        one-cycle pulse on PLAY -> LOST
//
// Build option: define PIPE_SPEEDUP_EN to make the scroll step grow with the
// score, as min(1 + score/SPEEDUP_EVERY, MAX_STEP). Without the macro the
// step is a constant 1.
module flappy_game_ctrl #(
    parameter int NUM_PIPES     = 2,
    parameter int X_W           = 11,
    parameter int Y_W           = 9,
    parameter int SCORE_W       = 4,
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int PIPE_W        = 40,
    parameter int PIPE_SPACING  = 360,
    parameter int GAP_H         = 140,
    parameter int GAP_MIN       = 60,
    parameter int GAP_MASK      = 127,
    parameter int INIT_GAP      = 100,
    parameter int BIRD_X        = 264,
    parameter int BIRD_HALF     = 20,
    parameter int SPEEDUP_EVERY = 4,
    parameter int MAX_STEP      = 4
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       tick,
    input  logic                       jump,
    input  logic                       pause_btn,
    input  logic                       restart,
    input  logic [Y_W-1:0]             bird_y,
    input  logic [7:0]                 rand_byte,
    output logic [1:0]                 state,
    output logic [NUM_PIPES*X_W-1:0]   pipe_x,
    output logic [NUM_PIPES*Y_W-1:0]   gap_y,
    output logic [SCORE_W-1:0]         score,
    output logic [SCORE_W-1:0]         high_score,
    output logic                       hit
);

    localparam logic [1:0] ST_LOST  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_PLAY  = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

`ifdef PIPE_SPEEDUP_EN
    localparam bit SPEEDUP_ON = 1'b1;
`else
    localparam bit SPEEDUP_ON = 1'b0;
`endif

    localparam int unsigned SCORE_MAX = (1 << SCORE_W) - 1;

    // Collision geometry is evaluated with two extra bits of signed headroom
    // so that "x - width" and "y - half" never wrap around zero.
    localparam logic signed [X_W+1:0] BX_LO_S = $signed((X_W+2)'(BIRD_X - BIRD_HALF));
    localparam logic signed [X_W+1:0] BX_HI_S = $signed((X_W+2)'(BIRD_X + BIRD_HALF));
    localparam logic signed [X_W+1:0] PW_S    = $signed((X_W+2)'(PIPE_W));
    localparam logic signed [Y_W+1:0] BH_S    = $signed((Y_W+2)'(BIRD_HALF));
    localparam logic signed [Y_W+1:0] GH_S    = $signed((Y_W+2)'(GAP_H));
    localparam logic signed [Y_W+1:0] SH_S    = $signed((Y_W+2)'(SCREEN_H));

    function automatic logic [X_W-1:0] init_x(input int idx);
        return X_W'(SCREEN_W + PIPE_W + idx * PIPE_SPACING);
    endfunction

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input int unsigned      n);
        int unsigned sum;
        sum = 32'(a) + n;
        if (sum > SCORE_MAX)
            return SCORE_W'(SCORE_MAX);
        return SCORE_W'(sum);
    endfunction

    function automatic logic [X_W-1:0] step_for(input logic [SCORE_W-1:0] s);
        int st;
        st = 1 + int'(s) / SPEEDUP_EVERY;
        if (st > MAX_STEP)
            st = MAX_STEP;
        return X_W'(st);
    endfunction

    logic [X_W-1:0]         px_q    [NUM_PIPES];
    logic [Y_W-1:0]         gap_q   [NUM_PIPES];
    logic [X_W-1:0]         px_nxt  [NUM_PIPES];
    logic [Y_W-1:0]         gap_nxt [NUM_PIPES];
    logic [NUM_PIPES-1:0]   coll_pipe;
    logic                   pause_btn_p0;
    logic                   pause_edge;
    logic                   edge_coll;
    logic                   collide;
    logic                   scroll_en;
    logic [X_W-1:0]         step;
    logic [Y_W-1:0]         new_gap;
    logic [SCORE_W-1:0]     score_nxt;
    int unsigned            n_rec;

    logic signed [Y_W+1:0]  bird_s;
    logic signed [Y_W+1:0]  bird_top_s;
    logic signed [Y_W+1:0]  bird_bot_s;

    // ---- combinational: collision on registered pipes + current bird_y ----
    assign bird_s     = $signed({2'b00, bird_y});
    assign bird_top_s = bird_s - BH_S;
    assign bird_bot_s = bird_s + BH_S;
    assign edge_coll  = (bird_s <= BH_S) || (bird_bot_s >= SH_S);

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        logic signed [X_W+1:0] right_s;
        logic signed [X_W+1:0] left_s;
        logic signed [Y_W+1:0] top_s;
        logic signed [Y_W+1:0] bot_s;

        assign right_s = $signed({2'b00, px_q[i]});
        assign left_s  = right_s - PW_S;
        assign top_s   = $signed({2'b00, gap_q[i]});
        assign bot_s   = top_s + GH_S;

        assign coll_pipe[i] = (right_s > BX_LO_S) && (left_s < BX_HI_S) &&
                              ((bird_top_s < top_s) || (bird_bot_s > bot_s));

        assign pipe_x[i*X_W +: X_W] = px_q[i];
        assign gap_y[i*Y_W +: Y_W]  = gap_q[i];
    end

    assign collide    = edge_coll || (|coll_pipe);
    assign pause_edge = pause_btn & ~pause_btn_p0;
    assign scroll_en  = (state == ST_PLAY) && tick && !collide;
    assign step       = SPEEDUP_ON ? step_for(score) : X_W'(1);
    assign new_gap    = Y_W'(GAP_MIN + (int'(rand_byte) & GAP_MASK));

    // ---- combinational: next pipe positions and score for a scroll tick ----
    always_comb begin
        n_rec = 0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (px_q[i] < step) begin
                // Pipe left the screen: move it behind the last one in flight.
                px_nxt[i]  = px_q[i] + X_W'(NUM_PIPES * PIPE_SPACING) - step;
                gap_nxt[i] = new_gap;
                n_rec      = n_rec + 1;
            end else begin
                px_nxt[i]  = px_q[i] - step;
                gap_nxt[i] = gap_q[i];
            end
        end
        score_nxt = sat_add(score, n_rec);
    end

    // ---- registered state ----
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= ST_READY;
            score        <= '0;
            high_score   <= '0;
            hit          <= 1'b0;
            pause_btn_p0 <= 1'b0;
            for (int i = 0; i < NUM_PIPES; i++) begin
                px_q[i]  <= init_x(i);
                gap_q[i] <= Y_W'(INIT_GAP);
            end
        end else begin
            pause_btn_p0 <= pause_btn;
            hit          <= 1'b0;
            // high_score follows the registered score, so it lags by a cycle.
            if (score > high_score)
                high_score <= score;

            if (restart) begin
                state <= ST_READY;
                score <= '0;
                for (int i = 0; i < NUM_PIPES; i++) begin
                    px_q[i]  <= init_x(i);
                    gap_q[i] <= Y_W'(INIT_GAP);
                end
            end else begin
                if (scroll_en) begin
                    score <= score_nxt;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        px_q[i]  <= px_nxt[i];
                        gap_q[i] <= gap_nxt[i];
                    end
                end

                case (state)
                    ST_PLAY: begin
                        if (collide) begin
                            state <= ST_LOST;
                            hit   <= 1'b1;
                        end else if (pause_edge) begin
                            state <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        if (pause_edge)
                            state <= ST_PLAY;
                    end
                    ST_READY: begin
                        if (jump)
                            state <= ST_PLAY;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Testbench for flappy_game_ctrl: directed scenarios plus randomized stimulus,
// all outputs compared every cycle against a behavioural game model.
module tb_flappy_game_ctrl;

    localparam int NP  = 2;
    localparam int XW  = 11;
    localparam int YW  = 9;
    localparam int SW  = 4;

    localparam int LOST = 0, READY = 1, PLAY = 2, PAUSE = 3;

    logic              clk;
    logic              clr, tick, jump, pause_btn, restart;
    logic [YW-1:0]     bird_y;
    logic [7:0]        rand_byte;
    logic [1:0]        state;
    logic [NP*XW-1:0]  pipe_x;
    logic [NP*YW-1:0]  gap_y;
    logic [SW-1:0]     score, high_score;
    logic              hit;

    int n_vec = 0;
    int n_err = 0;

    // behavioural model of the game
    int m_state, m_score, m_high, m_hit, m_pprev;
    int m_x [NP];
    int m_g [NP];

    flappy_game_ctrl dut (
        .clk        (clk),
        .clr        (clr),
        .tick       (tick),
        .jump       (jump),
        .pause_btn  (pause_btn),
        .restart    (restart),
        .bird_y     (bird_y),
        .rand_byte  (rand_byte),
        .state      (state),
        .pipe_x     (pipe_x),
        .gap_y      (gap_y),
        .score      (score),
        .high_score (high_score),
        .hit        (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int dut_x(input int i);
        return int'(pipe_x[i*XW +: XW]);
    endfunction

    function automatic int dut_g(input int i);
        return int'(gap_y[i*YW +: YW]);
    endfunction

    function automatic int m_step();
`ifdef PIPE_SPEEDUP_EN
        int s;
        s = 1 + m_score / 4;
        return (s > 4) ? 4 : s;
`else
        return 1;
`endif
    endfunction

    // Bird box [y-20, y+20] against each pipe's solid area and the screen edges.
    function automatic bit m_collide();
        int by;
        bit c;
        by = int'(bird_y);
        c  = (by <= 20) || (by + 20 >= 480);
        for (int i = 0; i < NP; i++) begin
            bit over, miss;
            over = (m_x[i] > 244) && (m_x[i] - 40 < 284);
            miss = (by - 20 < m_g[i]) || (by + 20 > m_g[i] + 140);
            if (over && miss) c = 1;
        end
        return c;
    endfunction

    task automatic m_new_round();
        m_state = READY;
        m_score = 0;
        for (int i = 0; i < NP; i++) begin
            m_x[i] = 680 + i * 360;
            m_g[i] = 100;
        end
    endtask

    // Advance the model by one clock edge with the inputs currently applied.
    task automatic model_edge();
        bit col, pe;
        int st, rec;
        col = m_collide();
        pe  = pause_btn && (m_pprev == 0);
        m_hit = 0;
        if (clr) begin
            m_new_round();
            m_high  = 0;
            m_pprev = 0;
            return;
        end
        m_pprev = int'(pause_btn);
        if (m_score > m_high) m_high = m_score;
        if (restart) begin
            m_new_round();
            return;
        end
        if (m_state == PLAY && tick && !col) begin
            st  = m_step();
            rec = 0;
            for (int i = 0; i < NP; i++) begin
                if (m_x[i] < st) begin
                    m_x[i] = m_x[i] + NP * 360 - st;
                    m_g[i] = 60 + (int'(rand_byte) % 128);
                    rec++;
                end else begin
                    m_x[i] = m_x[i] - st;
                end
            end
            m_score = (m_score + rec > 15) ? 15 : m_score + rec;
        end
        if (m_state == PLAY) begin
            if (col) begin
                m_state = LOST;
                m_hit   = 1;
            end else if (pe) begin
                m_state = PAUSE;
            end
        end else if (m_state == PAUSE) begin
            if (pe) m_state = PLAY;
        end else if (m_state == READY) begin
            if (jump) m_state = PLAY;
        end
    endtask

    task automatic check_all();
        chk("state", state, m_state);
        chk("score", score, m_score);
        chk("high_score", high_score, m_high);
        chk("hit", hit, m_hit);
        for (int i = 0; i < NP; i++) begin
            chk($sformatf("pipe_x%0d", i), dut_x(i), m_x[i]);
            chk($sformatf("gap_y%0d", i), dut_g(i), m_g[i]);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    task automatic do_restart_and_start(input int by);
        tick = 0; restart = 1; run(1); restart = 0;
        jump = 1; run(1); jump = 0;
        bird_y = YW'(by);
    endtask

    initial begin
        int rec_x, b1;
        bit seen4, seen12;
        seen4 = 0; seen12 = 0;
        clr = 1; tick = 0; jump = 0; pause_btn = 0; restart = 0;
        bird_y = 9'd170; rand_byte = 8'h00;
        m_high = 0; m_pprev = 0; m_hit = 0;
        m_new_round();

        // reset and start
        run(2);
        clr = 0;
        chk("rst_state", state, READY);
        chk("rst_score", score, 0);
        chk("rst_high", high_score, 0);
        chk("rst_hit", hit, 0);
        jump = 1; run(1); jump = 0;
        chk("start_state", state, PLAY);
        chk("start_x0", dut_x(0), 680);
        chk("start_x1", dut_x(1), 1040);
        chk("start_g0", dut_g(0), 100);
        chk("start_g1", dut_g(1), 100);

        // recycle and score
        tick = 1; run(680);
        chk("pipe0_zero", dut_x(0), 0);
        rand_byte = 8'h85; run(1);
        chk("recyc_x0", dut_x(0), 719);
        chk("recyc_g0", dut_g(0), 65);
        chk("recyc_score", score, 1);
        chk("high_lag", high_score, 0);
        tick = 0; run(1);
        chk("high_one", high_score, 1);

        // collision
        do_restart_and_start(240);
        tick = 1; run(357);
        chk("coll_x0", dut_x(0), 323);
        chk("coll_pre_hit", hit, 0);
        run(1);
        chk("coll_hit", hit, 1);
        chk("coll_state", state, LOST);
        chk("coll_frozen", dut_x(0), 323);
        run(1);
        chk("coll_hit_drop", hit, 0);
        run(5);
        chk("lost_frozen", dut_x(0), 323);

        do_restart_and_start(170);
        tick = 1; run(358);
        chk("nocoll_state", state, PLAY);
        chk("nocoll_x0", dut_x(0), 322);

        // pause
        tick = 0; pause_btn = 1; run(5);
        chk("pause_state", state, PAUSE);
        rec_x = dut_x(0);
        pause_btn = 0; tick = 1; run(10);
        chk("pause_frozen", dut_x(0), rec_x);
        tick = 0; pause_btn = 1; run(1);
        chk("resume_state", state, PLAY);
        pause_btn = 0; tick = 1; run(1);
        chk("resume_scroll", dut_x(0), rec_x - 1);

        // saturation (gap 60 always fits bird_y=170)
        rand_byte = 8'h00; bird_y = 9'd170; tick = 1;
        for (int k = 0; k < 9000 && score != 4'd15; k++) begin
`ifdef PIPE_SPEEDUP_EN
            if (!seen4 && score == 4'd4 && dut_x(0) >= 2 && dut_x(1) >= 2) begin
                b1 = dut_x(1); run(1);
                chk("speed_step2", b1 - dut_x(1), 2);
                seen4 = 1;
            end else if (!seen12 && score >= 4'd12 && dut_x(0) >= 4 && dut_x(1) >= 4) begin
                b1 = dut_x(1); run(1);
                chk("speed_step4", b1 - dut_x(1), 4);
                seen12 = 1;
            end else
`endif
            run(1);
        end
        chk("sat_reach", score, 15);
`ifdef PIPE_SPEEDUP_EN
        chk("speed_seen4", seen4, 1);
        chk("speed_seen12", seen12, 1);
`endif
        run(800);
        chk("sat_hold", score, 15);
        bird_y = 9'd10; run(1);
        chk("edge_coll_state", state, LOST);
        tick = 0; restart = 1; run(1); restart = 0;
        chk("rs_state", state, READY);
        chk("rs_score", score, 0);
        chk("rs_high", high_score, 15);
        chk("rs_x0", dut_x(0), 680);
        chk("rs_x1", dut_x(1), 1040);

        // randomized play
        bird_y = 9'd170;
        for (int k = 0; k < 4000; k++) begin
            clr       = ($urandom_range(0, 999) == 0);
            restart   = ($urandom_range(0, 79) == 0);
            jump      = ($urandom_range(0, 3) == 0);
            tick      = ($urandom_range(0, 3) != 0);
            rand_byte = 8'($urandom);
            if ($urandom_range(0, 15) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(0, 31) == 0)
                bird_y = YW'($urandom_range(0, 511));
            else if ($urandom_range(0, 31) == 0)
                bird_y = YW'($urandom_range(140, 200));
            run(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
